// File: rtl/sar_search.sv
// sar_search: recovers a signed N-bit target, MSB first, by probing an external less-than comparator.
module sar_search #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  output logic         busy_o,
  output logic [N-1:0] probe_o,
  output logic         probe_valid_o,
  input  logic         resp_valid_i,
  input  logic         resp_lt_i,
  output logic [N-1:0] result_o,
  output logic         done_o
);
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
  localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};
  state_t       state_q;
  logic [N-1:0] u_q, k_q, probe_q, result_q, u_d, trial_d;
  logic         busy_q, done_q, pv_q;
  // u is offset binary; flipping the MSB turns it into two's complement
  always_comb begin
    u_d     = resp_lt_i ? (u_q & ~k_q) : u_q;
    trial_d = u_d | (k_q >> 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      u_q      <= '0;
      k_q      <= '0;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= PROBE;
          u_q     <= MSB;
          k_q     <= MSB;
          probe_q <= '0;
          busy_q  <= 1'b1;
          pv_q    <= 1'b1;
        end
        PROBE: if (resp_valid_i) begin
          if (k_q[0]) begin
            state_q  <= DONE;
            result_q <= u_d ^ MSB;
            done_q   <= 1'b1;
            pv_q     <= 1'b0;
            probe_q  <= '0;
            u_q      <= '0;
            k_q      <= '0;
          end else begin
            u_q     <= trial_d;
            k_q     <= k_q >> 1;
            probe_q <= trial_d ^ MSB;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy_o        = busy_q;
  assign probe_o       = probe_q;
  assign probe_valid_o = pv_q;
  assign result_o      = result_q;
  assign done_o        = done_q;
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed searches against a combinational comparator, checked every cycle by a timing model.
module tb_sar_search;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy_o, probe_valid_o, done_o, resp_valid, resp_lt;
  logic [N-1:0] probe_o, result_o;
  logic         rv_stall = 1'b0;
  int           cyc = 0;
  int           tgt = 0;
  logic [N-1:0] tgt8;
  int           tests = 0, fails = 0;
  logic [N-1:0] seen[$];
  logic         m_busy = 1'b0, m_pv = 1'b0, m_done = 1'b0;
  int           m_idx = 0, m_res = 0, m_tgt = 0;

  sar_search #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy_o), .probe_o(probe_o),
    .probe_valid_o(probe_valid_o), .resp_valid_i(resp_valid), .resp_lt_i(resp_lt),
    .result_o(result_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tgt8       = tgt[N-1:0];
  assign resp_lt    = $signed(tgt8) < $signed(probe_o);
  assign resp_valid = rv_stall ? (cyc % 3 == 0) : 1'b1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // The i-th probe keeps the target's top i offset-binary bits and sets the next one as trial.
  function automatic logic [N-1:0] exp_probe(input int t, input int i);
    int ub, p;
    ub = t + 128;
    p  = ((ub >> (N - i)) << (N - i)) + (128 >> i) - 128;
    return p[N-1:0];
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 1'b0; m_pv <= 1'b0; m_done <= 1'b0; m_idx <= 0; m_res <= 0;
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_pv <= 1'b1; m_idx <= 0; m_tgt <= tgt;
      end
    end else if (m_pv && resp_valid) begin
      if (m_idx == N - 1) begin
        m_pv <= 1'b0; m_done <= 1'b1; m_res <= m_tgt;
      end
      m_idx <= m_idx + 1;
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("busy", busy_o, m_busy);
      chk("probe_valid", probe_valid_o, m_pv);
      chk("done", done_o, m_done);
      chk("probe", probe_o, m_pv ? exp_probe(m_tgt, m_idx) : '0);
      chk("result", result_o, m_res[N-1:0]);
      if (probe_valid_o && resp_valid) seen.push_back(probe_o);
    end

  task automatic run(input int t, input bit stall, input bit poke, output int dc);
    tgt = t; rv_stall = stall; seen.delete(); dc = -1;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = poke && (c == 2 || c == 5);
      if (done_o) begin
        dc = c;
        break;
      end
    end
    start = 1'b0;
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("busy_after_done", busy_o, 1'b0);
    rv_stall = 1'b0;
  endtask

  task automatic chk_seq(input string n, input logic [N-1:0] e[N]);
    chk({n, "_count"}, seen.size(), N);
    for (int i = 0; i < N && i < seen.size(); i++) chk(n, seen[i], e[i]);
  endtask

  initial begin
    int dc;
    logic [N-1:0] seq0[N]   = '{8'h00, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [N-1:0] seqm128[N] = '{8'h00, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81};
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_pv", probe_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_probe", probe_o, 8'h00);
    chk("rst_result", result_o, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(0, 1'b0, 1'b0, dc);
    chk("t0_done_cycle", dc, 9);
    chk("t0_result", result_o, 8'h00);
    chk_seq("t0_probe_seq", seq0);
    run(-128, 1'b0, 1'b0, dc);
    chk("tm128_done_cycle", dc, 9);
    chk("tm128_result", result_o, 8'h80);
    chk_seq("tm128_probe_seq", seqm128);
    run(127, 1'b0, 1'b0, dc);
    chk("t127_result", result_o, 8'h7F);
    run(-1, 1'b0, 1'b0, dc);
    chk("tm1_result", result_o, 8'hFF);
    if (seen.size() == N) begin
      chk("tm1_probe1", seen[1], 8'hC0);
      chk("tm1_probe7", seen[7], 8'hFF);
    end else chk("tm1_count", seen.size(), N);
    run(37, 1'b1, 1'b0, dc);
    chk("t37_stall_result", result_o, 8'h25);
    chk("t37_stall_done_window", (dc >= 3 * N - 2 && dc <= 3 * N + 1), 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_result_hold", result_o, 8'h25);
    run(37, 1'b0, 1'b1, dc);
    chk("t37_poke_done_cycle", dc, 9);
    chk("t37_poke_result", result_o, 8'h25);
    tgt = 37;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_pv", probe_valid_o, 1'b0);
    chk("abort_probe", probe_o, 8'h00);
    chk("abort_result", result_o, 8'h00);
    chk("abort_done", done_o, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run(-50, 1'b0, 1'b0, dc);
    chk("tm50_done_cycle", dc, 9);
    chk("tm50_result", result_o, 8'hCE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sar_search.md
# sar_search

Sequential successive-approximation searcher that recovers an unknown signed N-bit value by driving probes into an external "less-than" comparator and consuming its one-bit answers. It is the consumer side of the comparator interface. The block owns the operand and the decision sequence, and the comparator only answers. It sits beside the ALU/comparator datapath and is used for threshold discovery and for comparator self-test. One search costs N probe/response exchanges, MSB first.

## Interface
- N, 32, data width in bits; two's-complement signed; N ≥ 2
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new search; accepted only when busy = 0
- busy  output  1  high from the cycle after start is accepted through the cycle done is high
- probe  output  N  signed candidate presented to the comparator as operand b (target is operand a)
- probe_valid  output  1  probe is valid and held stable until the response handshake completes
- resp_valid  input  1  comparator answer valid; the handshake completes on a clock edge where probe_valid & resp_valid
- resp_lt  input  1  comparator answer: 1 means target < probe (signed)
- result  output  N  recovered target; holds its value until the next accepted start
- done  output  1  one-cycle pulse when result is updated

## Operation
- The search works on an internal offset-binary register u[N-1:0] and a one-hot bit pointer k.
  - probe = u ^ (1 << (N-1)), which maps offset binary to two's complement.
- States and transitions:
  - IDLE: busy = 0, probe_valid = 0.
    - start → PROBE, with u = 1 << (N-1) and k = N-1.
  - PROBE: probe_valid = 1; bit k of u is set (trial bit).
    - On handshake: if resp_lt = 1, clear u[k]; otherwise keep it.
    - If k > 0: set u[k-1] = 1, decrement k, stay in PROBE.
    - If k = 0: → DONE.
    - Without a handshake, u, k and probe hold unchanged.
  - DONE: result ← u ^ (1 << (N-1)), done = 1 for exactly this cycle, → IDLE.
    - The result register is written on the PROBE→DONE edge, so result is valid while done is high.
- Exactly N handshakes per search; result equals the target whenever the comparator answers consistently.
- Signed range: result ∈ [-2^(N-1), 2^(N-1)-1]. Both extremes are reachable, with no wrap or special case.
- start while busy = 1 is ignored.
- resp_valid while probe_valid = 0 is ignored.
- An inconsistent comparator is not detected; result is whatever the bit decisions produce.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state = IDLE
  - busy = 0, probe_valid = 0, done = 0
  - probe = 0 (u = 0 while idle, so probe reads the offset of 0 → drive probe = 0 explicitly in IDLE)
  - result = 0
- Reset mid-search abandons the search. result keeps its reset value 0, and no done pulse is issued.
- start sampled at edge E0 → PROBE from E0+. The first probe, 0 in signed terms, is visible in the cycle after E0.
- With resp_valid tied high, probes occupy cycles 1…N after start, done pulses in cycle N+1, and busy is low in cycle N+2.
  - A new start is accepted in cycle N+2, giving back-to-back searches with an N+2 cycle period.
- Each response stall extends the search by one cycle per stalled cycle. The probe value is unchanged during a stall.
- resp_lt is sampled only on handshake edges. The comparator may be purely combinational, so resp_valid can be asserted in the same cycle as probe_valid.
- done and busy are registered outputs. probe and probe_valid are registered, with no combinational path from resp_* to any output.

## Test plan
- N=8, target 0, combinational comparator, resp_valid=1 → probes 0x00, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01; result 0x00; done in cycle 9.
- N=8, target −128 (0x80) → every resp_lt=1 except the first probe 0x00 (also lt) → result 0x80; probe sequence 0x00, 0xC0, 0xA0, …, 0x81.
- N=8, targets 127 and −1 → results 0x7F and 0xFF. The first probe for −1 answers lt=1, and all later probes answer lt=0.
- N=8, target 37, resp_valid asserted only every 3rd cycle → the probe is held stable across stalls, result 0x25, and done arrives 3N+1 cycles after start (±phase).
- start pulsed in cycles 2 and 5 of an active search, and stray resp_valid in IDLE → no restart and no state change; result is correct for the original target.
- rst_n low for 1 cycle at probe 4, then a fresh start with target −50 → outputs go to reset values immediately, no done for the aborted search; the new search gives result 0xCE.
